// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   Parametrised oversampling UART receiver. Brings the asynchronous pad line
//   through a 2-flop synchroniser, finds start edges, rejects false starts,
//   shifts DATA_BITS payload bits LSB first, checks optional parity and one or
//   two stop bits, and flags break frames. A received word sits in a
//   valid/ready output register. A frame that completes while the previous
//   word is still unaccepted is dropped, and overrun pulses.
//
//   Optional build macro: UART_RX_MAJORITY_EN
//     defined     - each bit (start bit included) is the 2-of-3 majority of
//                   the samples at cnt OVERSAMPLE/2-1, /2 and /2+1. The value
//                   is resolved at /2+1.
//     not defined - each bit is a single sample taken at cnt OVERSAMPLE/2.
//
// Parameters
//   OVERSAMPLE  baud_tick pulses per bit time (even, >= 4)
//   DATA_BITS   payload bits per frame (5..9)
//   PARITY      0 none, 1 odd, 2 even
//   STOP_BITS   1 or 2
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   baud_tick      oversample enable, one clk wide
//   rx             asynchronous serial line, idle high
//   data           received word, held while valid
//   valid          word available
//   ready          consumer takes the word when valid & ready
//   parity_error   parity mismatch status of the held word
//   framing_error  a stop bit of the held word sampled 0
//   overrun        one-clk pulse: a completed frame was dropped
//   break_detect   one-clk pulse: a break frame was received
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 break_detect
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  generate
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
      $error("uart_rx_cfg: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                 state, state_n;
  logic                   rx_meta, rx_s;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_acc;     // XOR of data bits and parity bit
  logic                   par_bit;
  logic                   ferr_q;
  logic                   stop0_q;     // value of the first stop bit
  logic                   prev_rx;
  logic                   bit_val;     // resolved value of the current bit
  logic                   tick_mid;    // bit value is valid on this tick
  logic                   tick_end;    // last tick of the bit time
  logic                   frame_done;
  logic                   frame_perr;
  logic                   frame_ferr;
  logic                   frame_brk;
  logic                   stop0_val;

  // Two-flop synchroniser. It resets to the idle level so that leaving
  // reset does not look like a start edge.
  // NOTE: clocked state always uses non-blocking (<=). Each flop then
  // samples the value from before the edge, so the two stages really
  // delay the signal by two clocks instead of collapsing into one wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_PRE     = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_RESOLVE = CW'(OVERSAMPLE / 2 + 1);

  logic samp_a, samp_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (baud_tick) begin
      if (cnt == CNT_PRE) samp_a <= rx_s;
      if (cnt == CNT_MID) samp_b <= rx_s;
    end
  end

  // The third vote is the live sample at CNT_RESOLVE.
  assign bit_val = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
`else
  localparam logic [CW-1:0] CNT_RESOLVE = CNT_MID;

  assign bit_val = rx_s;
`endif

  assign tick_mid = baud_tick && (cnt == CNT_RESOLVE);
  assign tick_end = baud_tick && (cnt == CNT_LAST);

  // Status of the frame that is completing on this tick.
  // A single stop bit is sampled on the completion tick itself, so its value
  // is not in stop0_q yet.
  assign stop0_val  = (bit_cnt == '0) ? bit_val : stop0_q;
  assign frame_ferr = ferr_q | ~bit_val;
  assign frame_perr = (PARITY == 1) ? ~par_acc :
                      (PARITY == 2) ?  par_acc : 1'b0;
  assign frame_brk  = (shreg == '0) && !par_bit && !stop0_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: every signal written in this block is given a default first.
  // Without the defaults, any path that skips an assignment would make
  // synthesis infer a latch.
  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        // Arm only on a falling edge. After a break, prev_rx stays 0 until
        // the line has been seen high again.
        if (baud_tick && prev_rx && !rx_s) state_n = START;
      end
      START: begin
        if (tick_mid && bit_val) state_n = IDLE;   // false start
        else if (tick_end)       state_n = DATA;
      end
      DATA: begin
        if (tick_end && bit_cnt == DATA_LAST)
          state_n = (PARITY != 0) ? PAR : STOP;
      end
      PAR: begin
        if (tick_end) state_n = STOP;
      end
      STOP: begin
        // Finish at mid-bit of the last stop bit. The receiver is then idle
        // before the next start edge can arrive.
        if (tick_mid && bit_cnt == STOP_LAST) begin
          state_n    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      par_bit <= 1'b0;
      ferr_q  <= 1'b0;
      stop0_q <= 1'b0;
      prev_rx <= 1'b1;
    end else begin
      if (state == IDLE || state_n == IDLE) cnt <= '0;
      else if (baud_tick)                   cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

      if (state == IDLE)  bit_cnt <= '0;
      else if (tick_end)  bit_cnt <= (state_n != state) ? '0 : bit_cnt + BW'(1);

      if (state == IDLE) begin
        if (baud_tick) prev_rx <= rx_s;
      end else if (state_n == IDLE) begin
        prev_rx <= bit_val;
      end

      if (tick_mid) begin
        case (state)
          START: begin
            par_acc <= 1'b0;
            par_bit <= 1'b0;
            ferr_q  <= 1'b0;
          end
          DATA: begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            par_acc <= par_acc ^ bit_val;
          end
          PAR: begin
            par_acc <= par_acc ^ bit_val;
            par_bit <= bit_val;
          end
          STOP: begin
            if (!bit_val)        ferr_q  <= 1'b1;
            if (bit_cnt == '0)   stop0_q <= bit_val;
          end
          default: ;
        endcase
      end
    end
  end

  // Output register. A completing frame is loaded when the slot is free, or
  // when the held word is being taken on the same clk. Otherwise it is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data          <= '0;
      valid         <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      break_detect  <= 1'b0;
    end else begin
      overrun      <= 1'b0;
      break_detect <= 1'b0;
      if (frame_done) begin
        break_detect <= frame_brk;
        if (!valid || ready) begin
          data          <= shreg;
          parity_error  <= frame_perr;
          framing_error <= frame_ferr;
          valid         <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid         <= 1'b0;
        parity_error  <= 1'b0;
        framing_error <= 1'b0;
      end
    end
  end

endmodule
